// File: rtl/chseq_pkg.sv
// Shared types for the channel sequencer: sample width default, index-width helper, FSM states.
package chseq_pkg;

    localparam int CHSEQ_DATA_W = 8;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    // Index width for n channels; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/channel_sequencer_rr_arbiter.sv
// Combinational rotating-priority pick: first set req bit at or after ptr, wrapping; zero latency.
module rr_arbiter #(
    parameter int NUM_CH = 32,
    parameter int IDX_W  = 5
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_onehot_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              any_o
);

    always_comb begin : pick
        int idx;
        idx          = 0;
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        any_o        = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any_o && req_i[idx]) begin
                any_o             = 1'b1;
                gnt_idx_o         = IDX_W'(idx);
                gnt_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_sequencer.sv
// Round-robin mux of NUM_CH sample streams onto one tagged output; grant -> out_valid next cycle,
// one beat/cycle when out_ready holds, ch_ready low while stalled. CHSEQ_STALL_CNT_EN adds a stall counter.
module channel_sequencer
    import chseq_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int DATA_W = CHSEQ_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [idx_w(NUM_CH)-1:0]  out_ch,
    output logic                      out_wrap
`ifdef CHSEQ_STALL_CNT_EN
    ,
    input  logic                      stall_clr,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int IW = idx_w(NUM_CH);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   req, gnt_onehot;
    logic [IW-1:0]       gnt_idx;
    logic                any, grant;
    logic [IW-1:0]       ptr_q, ptr_d, last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d, gnt_data;
    logic [IW-1:0]       ch_q, ch_d;
    logic                wrap_q, wrap_d;

    assign req = ch_valid & ch_en;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IW)
    ) u_arb (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .any_o        (any)
    );

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_onehot[i]) gnt_data = ch_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        data_d  = data_q;
        ch_d    = ch_q;
        wrap_d  = wrap_q;
        grant   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                grant = any;
                if (any) state_d = S_FULL;
            end
            S_FULL: begin
                if (out_ready) begin
                    grant = any;
                    if (!any) state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Suppress grants during reset so no sample is lost to a discarded beat.
        if (rst) grant = 1'b0;
        if (grant) begin
            data_d = gnt_data;
            ch_d   = gnt_idx;
            wrap_d = (gnt_idx <= last_q);
            last_d = gnt_idx;
            ptr_d  = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            last_q  <= IW'(NUM_CH - 1);
            data_q  <= '0;
            ch_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ch_ready  = grant ? gnt_onehot : '0;
    assign out_valid = (state_q == S_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_wrap  = wrap_q;

`ifdef CHSEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_channel_sequencer.sv
// Randomized and directed bench for channel_sequencer against a scan-order reference model.
module tb_channel_sequencer;

    localparam int N  = 32;
    localparam int DW = 8;
    localparam int IW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      ch_en, ch_valid, ch_ready;
    logic [N*DW-1:0]   ch_data;
    logic              out_valid, out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_ch;
    logic              out_wrap;
`ifdef CHSEQ_STALL_CNT_EN
    logic              stall_clr;
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    channel_sequencer #(.NUM_CH(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .ch_ready  (ch_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_wrap  (out_wrap)
`ifdef CHSEQ_STALL_CNT_EN
        ,
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
`endif
    );

    // Reference model: scan pointer, index of last grant, and the beat the output should hold.
    int          m_ptr, m_last, m_ch;
    bit          m_full, m_wrap;
    logic [7:0]  m_data;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        int         ch;
        bit         wrap;
        logic [7:0] data;
    } beat_t;
    beat_t beats[$];

    localparam logic [N-1:0] ALL = '1;

    function automatic int winner(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data_pattern();
        for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = 8'(i * 7 + 3);
    endtask

    task automatic set_data_random();
        for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = 8'($urandom);
    endtask

    // One clock: drive, compare at negedge, advance the model at posedge.
    task automatic step(input logic r, input logic [N-1:0] en, input logic [N-1:0] v, input logic orr);
        logic [N-1:0] exp_rdy;
        int w;
        rst       = r;
        ch_en     = en;
        ch_valid  = v;
        out_ready = orr;
        w = winner(v & en, m_ptr);
        exp_rdy = '0;
        if (!r && (!m_full || orr) && w >= 0) exp_rdy[w] = 1'b1;
        @(negedge clk);
        chk("ch_ready", ch_ready, exp_rdy);
        chk("out_valid", out_valid, m_full);
        if (m_full) begin
            chk("out_ch", out_ch, m_ch);
            chk("out_data", out_data, m_data);
            chk("out_wrap", out_wrap, m_wrap);
            if (orr && !r) beats.push_back('{int'(out_ch), out_wrap, out_data});
        end
        @(posedge clk);
        if (r) begin
            m_full = 0;
            m_ptr  = 0;
            m_last = N - 1;
        end else begin
            if (m_full && orr) m_full = 0;
            if (!m_full && w >= 0) begin
                m_full = 1;
                m_ch   = w;
                m_data = ch_data[w*DW +: DW];
                m_wrap = (w <= m_last);
                m_last = w;
                m_ptr  = (w + 1) % N;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, ALL, ALL, 1'b1);
        step(1'b1, ALL, ALL, 1'b1);
    endtask

    initial begin
        logic [N-1:0] en, v;
        rst = 1'b1; ch_en = '0; ch_valid = '0; out_ready = 1'b0; ch_data = '0;
`ifdef CHSEQ_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        m_ptr = 0; m_last = N - 1; m_full = 0; m_ch = 0; m_wrap = 0; m_data = '0;
        set_data_pattern();

        // Reset values
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ch", out_ch, 5'd0);
        chk("rst_out_wrap", out_wrap, 1'b0);
        chk("rst_ch_ready", ch_ready, '0);

        // Full scan: 0..31 then 0 again, wrap only on ch0
        beats.delete();
        for (int i = 0; i < 34; i++) step(1'b0, ALL, ALL, 1'b1);
        chk("scan_beats", beats.size(), 33);
        for (int k = 0; k < 33 && k < beats.size(); k++) begin
            chk("scan_ch", beats[k].ch, k % N);
            chk("scan_wrap", beats[k].wrap, (k % N) == 0);
        end
        if (beats.size() >= 33) begin
            chk("scan_b31", beats[31].ch, 31);
            chk("scan_b32_wrap", beats[32].wrap, 1'b1);
            chk("scan_b5_data", beats[5].data, 8'd38);
        end

        // Two enabled channels alternate
        do_reset();
        beats.delete();
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0000_0011, ALL, 1'b1);
        chk("alt_beats", beats.size(), 8);
        for (int k = 0; k < 8 && k < beats.size(); k++) begin
            chk("alt_ch", beats[k].ch, (k % 2) ? 4 : 0);
            chk("alt_wrap", beats[k].wrap, (k % 2) == 0);
        end

        // Single requester, one beat per cycle
        do_reset();
        ch_data[7*DW +: DW] = 8'hA5;
        beats.delete();
        for (int i = 0; i < 8; i++) step(1'b0, ALL, 32'h0000_0080, 1'b1);
        chk("single_beats", beats.size(), 7);
        foreach (beats[k]) begin
            chk("single_ch", beats[k].ch, 7);
            chk("single_data", beats[k].data, 8'hA5);
            chk("single_wrap", beats[k].wrap, 1'b1);
        end

        // Backpressure: hold ch2 for 5 cycles, then resume with ch3
        set_data_pattern();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, ALL, ALL, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, ALL, ALL, 1'b0);
            chk("hold_ch", out_ch, 5'd2);
            chk("hold_data", out_data, 8'd17);
            chk("hold_valid", out_valid, 1'b1);
        end
        beats.delete();
        step(1'b0, ALL, ALL, 1'b1);
        step(1'b0, ALL, ALL, 1'b1);
        chk("resume_n", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("resume_b0", beats[0].ch, 2);
            chk("resume_b1", beats[1].ch, 3);
        end

        // Reset while a beat is held
        for (int i = 0; i < 4; i++) step(1'b0, ALL, ALL, 1'b1);
        step(1'b0, ALL, ALL, 1'b0);
        step(1'b1, ALL, ALL, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        beats.delete();
        for (int i = 0; i < 3; i++) step(1'b0, ALL, ALL, 1'b1);
        if (beats.size() > 0) begin
            chk("midrst_ch", beats[0].ch, 0);
            chk("midrst_wrap", beats[0].wrap, 1'b1);
        end else begin
            chk("midrst_beats", beats.size(), 2);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_data_random();
            case ($urandom % 3)
                0:       en = ALL;
                1:       en = $urandom & $urandom;
                default: en = $urandom;
            endcase
            v = ($urandom % 2) ? ALL : N'($urandom);
            step(($urandom % 150) == 0, en, v, ($urandom % 4) != 0);
        end

`ifdef CHSEQ_STALL_CNT_EN
        do_reset();
        chk("stall_rst", stall_cnt, 16'h0000);
        step(1'b0, ALL, ALL, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", stall_cnt, 16'hFFFF);
        stall_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_clr", stall_cnt, 16'h0000);
        stall_clr = 1'b0;
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
